// File: rtl/sd_bd_fetch.sv
// SD-side buffer-descriptor fetcher: reads one 4-word BD from BD memory,
// launches a single data transfer, waits for it, then returns the slot.
module sd_bd_fetch #(
  parameter int unsigned BD_WIDTH = 5,
  parameter int unsigned BD_COUNT = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [BD_WIDTH-1:0] bd_free,
  output logic                bd_re,
  input  logic                bd_ack,
  input  logic [DATA_W-1:0]   bd_dat,
  output logic                a_cmp,
  output logic                xfer_start,
  output logic [31:0]         xfer_buf_addr,
  output logic [31:0]         xfer_blk_addr,
  input  logic                xfer_done,
  input  logic                xfer_err,
  output logic                busy,
  output logic [CNT_W-1:0]    done_cnt,
  output logic                err_flag,
  input  logic                err_clr
);

  typedef enum logic [2:0] {
    StIdle, StReq, StWack, StIssue, StWxfer, StCmp, StGap
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [31:0]        buf_q, buf_d;
  logic [31:0]        blk_q, blk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_flag_q, err_flag_d;
  logic               xerr_q, xerr_d;
  logic [31:0]        free_ext;
  logic               pending_nz;

  // A free count at or above BD_COUNT is treated as nothing pending, never wrapped.
  assign free_ext   = 32'(bd_free);
  assign pending_nz = (free_ext < BD_COUNT);

  assign xfer_buf_addr = buf_q;
  assign xfer_blk_addr = blk_q;
  assign busy          = (state_q != StIdle);
  assign done_cnt      = cnt_q;
  assign err_flag      = err_flag_q;

  // State and datapath registers; async reset returns everything to zero/IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      buf_q      <= 32'd0;
      blk_q      <= 32'd0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      xerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      blk_q      <= blk_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      xerr_q     <= xerr_d;
    end
  end

  // Next-state, word capture and Moore strobes.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    blk_d      = blk_q;
    cnt_d      = cnt_q;
    xerr_d     = xerr_q;
    err_flag_d = err_flag_q;
    bd_re      = 1'b0;
    xfer_start = 1'b0;
    a_cmp      = 1'b0;

    // Clear first so a set in CMP below takes priority.
    if (err_clr) err_flag_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        idx_d = 2'd0;
        if (en && pending_nz) state_d = StReq;
      end
      StReq: begin
        bd_re   = 1'b1;
        state_d = StWack;
      end
      StWack: begin
        if (bd_ack) begin
          unique case (idx_q)
            2'd0: buf_d[15:0]  = bd_dat[15:0];
            2'd1: buf_d[31:16] = bd_dat[15:0];
            2'd2: blk_d[15:0]  = bd_dat[15:0];
            2'd3: blk_d[31:16] = bd_dat[15:0];
            default: ;
          endcase
          idx_d   = idx_q + 2'd1;
          state_d = (idx_q == 2'd3) ? StIssue : StReq;
        end
      end
      StIssue: begin
        xfer_start = 1'b1;
        state_d    = StWxfer;
      end
      StWxfer: begin
        // Done and error together is an error completion.
        if (xfer_done || xfer_err) begin
          xerr_d  = xfer_err;
          state_d = StCmp;
        end
      end
      StCmp: begin
        a_cmp = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (xerr_q) err_flag_d = 1'b1;
        state_d = StGap;
      end
      StGap: begin
        // Low cycle so BD memory sees a clean edge and IDLE sees the new count.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_sd_bd_fetch.sv
// Directed bench for sd_bd_fetch with a BD-memory responder, a lagging
// free-count model and an address scoreboard checked at each xfer_start.
module tb_sd_bd_fetch;

  logic        clk, rst, en;
  logic [4:0]  bd_free;
  logic        bd_re, bd_ack;
  logic [15:0] bd_dat;
  logic        a_cmp, xfer_start;
  logic [31:0] xfer_buf_addr, xfer_blk_addr;
  logic        xfer_done, xfer_err, busy;
  logic [15:0] done_cnt;
  logic        err_flag, err_clr;

  int checks = 0;
  int errors = 0;

  logic [15:0] rd_q[$];
  logic [63:0] exp_q[$];
  int          ack_delay = 0;
  bit          resp_en = 1'b1;
  int          ack_cnt_bd = 0;
  int          re_cnt = 0, start_cnt = 0, cmp_cnt = 0;
  logic [15:0] exp_done = 16'd0;
  logic        cmp_prev = 1'b0;
  logic        outstanding = 1'b0;

  sd_bd_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .bd_free       (bd_free),
    .bd_re         (bd_re),
    .bd_ack        (bd_ack),
    .bd_dat        (bd_dat),
    .a_cmp         (a_cmp),
    .xfer_start    (xfer_start),
    .xfer_buf_addr (xfer_buf_addr),
    .xfer_blk_addr (xfer_blk_addr),
    .xfer_done     (xfer_done),
    .xfer_err      (xfer_err),
    .busy          (busy),
    .done_cnt      (done_cnt),
    .err_flag      (err_flag),
    .err_clr       (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bd(input logic [31:0] b, input logic [31:0] k);
    rd_q.push_back(b[15:0]);
    rd_q.push_back(b[31:16]);
    rd_q.push_back(k[15:0]);
    rd_q.push_back(k[31:16]);
    exp_q.push_back({b, k});
  endtask

  task automatic wait_start(input int maxc, output int cyc);
    cyc = 0;
    while (xfer_start !== 1'b1 && cyc < maxc) begin
      step();
      cyc++;
    end
    check("start_seen", 64'(xfer_start), 64'd1);
  endtask

  task automatic finish_xfer(input logic d, input logic e);
    step();
    step();
    xfer_done = d;
    xfer_err  = e;
    step();
    xfer_done = 1'b0;
    xfer_err  = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < maxc) begin
      step();
      c++;
    end
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic manual_ack(input logic [15:0] w);
    int c;
    c = 0;
    while (bd_re !== 1'b1 && c < 20) begin
      step();
      c++;
    end
    check("manual_re", 64'(bd_re), 64'd1);
    step();
    bd_ack = 1'b1;
    bd_dat = w;
    ack_cnt_bd++;
    step();
    bd_ack = 1'b0;
    bd_dat = 16'd0;
  endtask

  // BD memory read responder: one ack per bd_re after ack_delay extra cycles.
  initial begin
    bd_ack = 1'b0;
    bd_dat = 16'd0;
    forever begin
      @(posedge clk);
      #1;
      while (bd_re === 1'b1 && resp_en) begin
        repeat (ack_delay) @(posedge clk);
        @(posedge clk);
        #1;
        bd_dat = (rd_q.size() > 0) ? rd_q.pop_front() : 16'hdead;
        bd_ack = 1'b1;
        ack_cnt_bd++;
        @(posedge clk);
        #1;
        bd_ack = 1'b0;
        bd_dat = 16'd0;
      end
    end
  end

  // Negedge monitor: scoreboard, pulse rules, and free-count model that
  // frees a slot one cycle after each a_cmp pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_prev) begin
        bd_free = bd_free + 5'd1;
        check("done_cnt_track", 64'(done_cnt), 64'(exp_done));
      end
      if (bd_re) begin
        re_cnt++;
        check("re_while_outstanding", 64'(outstanding), 64'd0);
        outstanding = 1'b1;
      end
      if (bd_ack) outstanding = 1'b0;
      if (xfer_start) begin
        logic [63:0] e;
        start_cnt++;
        check("acks_before_start", 64'(ack_cnt_bd), 64'd4);
        ack_cnt_bd = 0;
        check("exp_avail", 64'(exp_q.size() > 0), 64'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
        check("xfer_buf_addr", 64'(xfer_buf_addr), 64'(e[63:32]));
        check("xfer_blk_addr", 64'(xfer_blk_addr), 64'(e[31:0]));
      end
      if (a_cmp) begin
        cmp_cnt++;
        exp_done = exp_done + 16'd1;
        check("cmp_gap", 64'(cmp_prev), 64'd0);
        check("cmp_le_start", 64'(cmp_cnt <= start_cnt), 64'd1);
      end
      cmp_prev = a_cmp;
    end
  end

  initial begin
    int cyc, re0, cmp0;
    rst = 1'b1; en = 1'b0; bd_free = 5'd8;
    xfer_done = 1'b0; xfer_err = 1'b0; err_clr = 1'b0;
    step();
    step();
    check("rst_outputs",
          64'({bd_re, a_cmp, xfer_start, busy, err_flag}), 64'd0);
    check("rst_addrs", {xfer_buf_addr, xfer_blk_addr}, 64'd0);
    check("rst_done_cnt", 64'(done_cnt), 64'd0);
    rst = 1'b0;
    step();

    // Single BD, ack one cycle after each read.
    en = 1'b1;
    load_bd(32'h0002_1000, 32'h0000_0040);
    re0 = re_cnt;
    bd_free = 5'd7;
    wait_start(60, cyc);
    check("fetch_latency_min", 64'(cyc), 64'd9);
    finish_xfer(1'b1, 1'b0);
    wait_idle(20);
    check("single_re_count", 64'(re_cnt - re0), 64'd4);
    check("single_done_cnt", 64'(done_cnt), 64'd1);
    check("single_err_flag", 64'(err_flag), 64'd0);

    // Slow ack, five extra cycles per word.
    ack_delay = 5;
    load_bd(32'hcafe_0010, 32'h1234_5678);
    re0 = re_cnt;
    bd_free = 5'd7;
    wait_start(100, cyc);
    check("fetch_latency_slow", 64'(cyc), 64'd29);
    finish_xfer(1'b1, 1'b0);
    wait_idle(20);
    check("slow_re_count", 64'(re_cnt - re0), 64'd4);
    check("slow_done_cnt", 64'(done_cnt), 64'd2);
    ack_delay = 0;

    // Back-to-back BDs driven by the lagging free-count model.
    load_bd(32'h1111_2222, 32'h3333_4444);
    load_bd(32'h5555_6666, 32'h7777_8888);
    re0 = re_cnt;
    cmp0 = cmp_cnt;
    bd_free = 5'd6;
    for (int i = 0; i < 2; i++) begin
      wait_start(60, cyc);
      finish_xfer(1'b1, 1'b0);
    end
    wait_idle(20);
    repeat (10) step();
    check("b2b_re_count", 64'(re_cnt - re0), 64'd8);
    check("b2b_cmp_count", 64'(cmp_cnt - cmp0), 64'd2);
    check("b2b_done_cnt", 64'(done_cnt), 64'd4);
    check("b2b_idle", 64'(busy), 64'd0);

    // Error path: done and err together.
    load_bd(32'hdead_beef, 32'h0000_0100);
    bd_free = 5'd7;
    wait_start(60, cyc);
    finish_xfer(1'b1, 1'b1);
    wait_idle(20);
    check("err_flag_set", 64'(err_flag), 64'd1);
    check("err_done_cnt", 64'(done_cnt), 64'd5);
    // Clear first, then err_clr concurrent with the next error's CMP cycle.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr_alone", 64'(err_flag), 64'd0);
    load_bd(32'h0bad_0bad, 32'h0000_0200);
    bd_free = 5'd7;
    wait_start(60, cyc);
    step();
    step();
    xfer_err = 1'b1;
    step();
    xfer_err = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_set_beats_clr", 64'(err_flag), 64'd1);
    wait_idle(20);
    check("err2_done_cnt", 64'(done_cnt), 64'd6);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr_again", 64'(err_flag), 64'd0);

    // en low blocks fetch; dropping en mid-BD lets it finish.
    en = 1'b0;
    re0 = re_cnt;
    bd_free = 5'd7;
    repeat (20) step();
    check("en_low_no_re", 64'(re_cnt - re0), 64'd0);
    check("en_low_idle", 64'(busy), 64'd0);
    load_bd(32'h0000_abcd, 32'h00ff_0000);
    en = 1'b1;
    wait_start(60, cyc);
    en = 1'b0;
    finish_xfer(1'b1, 1'b0);
    wait_idle(20);
    check("en_drop_done_cnt", 64'(done_cnt), 64'd7);
    re0 = re_cnt;
    bd_free = 5'd6;
    repeat (10) step();
    check("en_drop_parked", 64'(busy), 64'd0);
    check("en_drop_no_re", 64'(re_cnt - re0), 64'd0);
    // Illegal free count over BD_COUNT.
    en = 1'b1;
    bd_free = 5'd9;
    repeat (20) step();
    check("free9_idle", 64'(busy), 64'd0);
    check("free9_no_re", 64'(re_cnt - re0), 64'd0);

    // Async reset after two acks, then a clean fetch from word 0.
    bd_free = 5'd8;
    step();
    resp_en = 1'b0;
    cmp0 = cmp_cnt;
    bd_free = 5'd7;
    manual_ack(16'h4321);
    manual_ack(16'h8765);
    rst = 1'b1;
    #1;
    check("abort_outputs",
          64'({bd_re, a_cmp, xfer_start, busy, err_flag}), 64'd0);
    check("abort_addrs", {xfer_buf_addr, xfer_blk_addr}, 64'd0);
    check("abort_done_cnt", 64'(done_cnt), 64'd0);
    step();
    step();
    outstanding = 1'b0;
    ack_cnt_bd = 0;
    exp_done = 16'd0;
    load_bd(32'h0000_0a0a, 32'h0000_0b0b);
    resp_en = 1'b1;
    check("abort_no_cmp", 64'(cmp_cnt - cmp0), 64'd0);
    rst = 1'b0;
    wait_start(60, cyc);
    check("refetch_latency", 64'(cyc), 64'd9);
    finish_xfer(1'b1, 1'b0);
    wait_idle(20);
    check("refetch_done_cnt", 64'(done_cnt), 64'd1);
    check("refetch_cmp_count", 64'(cmp_cnt - cmp0), 64'd1);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("words_drained", 64'(rd_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
